simon_seq_ctrl: RTL and testbench
=================================

// Module: simon_seq_ctrl
// PURPOSE
//  Parametrised Simon-Says sequencer controller: runs rounds of growing length (1..MAX_LEVEL),
//  requests random symbols, drives the pattern blinker, gates player input and judges each press.
//  Sits between the RNG, the pattern memory, the blinker, the input block and the comparator.
//  Adds explicit start, an input timeout, lose/win flags and a state code for the display.
// PARAMETERS
//  MAX_LEVEL    16      rounds to win; legal 2..255
//  TIMEOUT_CYC  50_000  cycles allowed per press in WAIT_IN; 0 disables timeout
//  LW           $clog2(MAX_LEVEL+1)  level/step width (derived, localparam)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  start_game    in   1   1-cycle pulse; honoured only in IDLE, WIN or LOSE
//  rng_ack       in   1   RNG has a symbol on its bus; write it this cycle
//  blinker_done  in   1   blinker finished showing blink_len symbols
//  input_done    in   1   player press captured (1-cycle pulse)
//  cmp_good      in   1   press at mem_addr matched; sampled in CHECK only
//  rng_req       out  1   request a new symbol (GEN)
//  mem_we        out  1   write pattern memory at mem_addr (GEN & rng_ack)
//  mem_addr      out  LW  GEN: level-1; WAIT_IN/CHECK: step
//  blink_start   out  1   1-cycle pulse on entry to BLINK
//  blink_len     out  LW  = level
//  input_en      out  1   WAIT_IN
//  cmp_en        out  1   CHECK
//  level         out  LW  current round, 0 in IDLE
//  step          out  LW  presses accepted this round
//  win, lose     out  1   sticky until start_game or reset
//  state_code    out  3   IDLE0 GEN1 BLINK2 WAIT_IN3 CHECK4 WIN5 LOSE6
// BEHAVIOUR
//  - Reset: state IDLE; level, step, timer, all outputs 0.
//  - All outputs Moore-decoded from registered state/counters except mem_we (= GEN & rng_ack).
//  - IDLE/WIN/LOSE --start_game--> GEN; level<=0, step<=0, win/lose<=0 on that edge.
//  - GEN: rng_req=1; hold until rng_ack; on ack: level<=level+1, step<=0 -> BLINK.
//    rng_ack absent for any number of cycles: wait, no timeout.
//  - BLINK: blink_start on first cycle only; blinker_done -> WAIT_IN, timer<=0.
//  - WAIT_IN: timer++ each cycle; input_done -> CHECK (timer<=0);
//    timer==TIMEOUT_CYC-1 without press -> LOSE. input_done on expiry cycle: press wins.
//  - CHECK (1 cycle): !cmp_good -> LOSE. cmp_good: step<=step+1, then
//    step+1<level -> WAIT_IN; step+1==level & level<MAX_LEVEL -> GEN; ==MAX_LEVEL -> WIN.
//  - WIN/LOSE: hold; level/step frozen for display; only start_game or reset exits.
//  - start_game outside IDLE/WIN/LOSE ignored. Reset mid-round aborts to IDLE immediately.
//  - Arithmetic unsigned LW bits; level never exceeds MAX_LEVEL so no wrap.
//  - Illegal state_code -> IDLE next cycle, outputs 0.
// CONFIGURATION
//  SIMON_RETRY_EN defined: a mismatch or timeout with lives>0 decrements 2-bit lives
//   (loaded 3 at start_game), step<=0 and replays via BLINK (same level, no new symbol);
//   lose only when lives==0. Adds output lives[1:0].
//  Not defined: any mismatch or timeout -> LOSE; no lives port.
// TESTING
//  1. reset high 1 cycle -> all outputs 0, state_code 0; start_game -> rng_req next cycle.
//  2. MAX_LEVEL=3, rng_ack 1 cycle after req, all presses good -> mem_we at addr 0,1,2; win=1
//     after 6th CHECK, state_code 5.
//  3. Level 2, 2nd press cmp_good=0 -> lose=1, level stays 2; start_game -> level 1 round.
//  4. TIMEOUT_CYC=10, no press -> LOSE exactly 10 cycles after WAIT_IN entry; press at
//     cycle 10 -> CHECK, no lose.
//  5. reset asserted in WAIT_IN -> IDLE next edge, win/lose/level 0; start_game ignored in BLINK.
//  6. SIMON_RETRY_EN: 3 bad presses -> replay BLINK at same level, lives 2,1,0; 4th -> lose.

Source files
------------

// File: rtl/simon_if.sv
// Handshake bundle between the Simon sequencer controller (master) and its
// RNG, pattern memory, blinker, input block and comparator (slave). Optional lives output under SIMON_RETRY_EN.
interface simon_if #(
  parameter int LW = 5
);
  logic          start_game;
  logic          rng_ack;
  logic          blinker_done;
  logic          input_done;
  logic          cmp_good;
  logic          rng_req;
  logic          mem_we;
  logic [LW-1:0] mem_addr;
  logic          blink_start;
  logic [LW-1:0] blink_len;
  logic          input_en;
  logic          cmp_en;
  logic [LW-1:0] level;
  logic [LW-1:0] step;
  logic          win;
  logic          lose;
  logic [2:0]    state_code;
`ifdef SIMON_RETRY_EN
  logic [1:0]    lives;

  modport master (
    input  start_game, rng_ack, blinker_done, input_done, cmp_good,
    output rng_req, mem_we, mem_addr, blink_start, blink_len, input_en, cmp_en,
    output level, step, win, lose, state_code, lives
  );
  modport slave (
    output start_game, rng_ack, blinker_done, input_done, cmp_good,
    input  rng_req, mem_we, mem_addr, blink_start, blink_len, input_en, cmp_en,
    input  level, step, win, lose, state_code, lives
  );
`else
  modport master (
    input  start_game, rng_ack, blinker_done, input_done, cmp_good,
    output rng_req, mem_we, mem_addr, blink_start, blink_len, input_en, cmp_en,
    output level, step, win, lose, state_code
  );
  modport slave (
    output start_game, rng_ack, blinker_done, input_done, cmp_good,
    input  rng_req, mem_we, mem_addr, blink_start, blink_len, input_en, cmp_en,
    input  level, step, win, lose, state_code
  );
`endif
endinterface

// File: rtl/simon_seq_ctrl.sv
// Simon-Says sequencer controller: grows the pattern one symbol per round, replays it and judges presses.
// Define SIMON_RETRY_EN to give the player three extra attempts (lives) per game.
module simon_seq_ctrl #(
  parameter int MAX_LEVEL   = 16,
  parameter int TIMEOUT_CYC = 50_000
) (
  input  logic    clk,
  input  logic    reset,
  simon_if.master bus
);
  localparam int LW = $clog2(MAX_LEVEL + 1);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LW-1:0] MAX_LVL    = LW'(MAX_LEVEL);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GEN     = 3'd1,
    S_BLINK   = 3'd2,
    S_WAIT_IN = 3'd3,
    S_CHECK   = 3'd4,
    S_WIN     = 3'd5,
    S_LOSE    = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] step_q, step_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          blink_first_q, blink_first_d;
  logic [1:0]    lives_q, lives_d;

  logic          retry_s;
  logic [LW-1:0] step_inc_s;
  logic          timeout_s;
  state_t        fail_state_s;
  logic [LW-1:0] fail_step_s;
  logic [1:0]    fail_lives_s;

`ifdef SIMON_RETRY_EN
  assign retry_s   = (lives_q != 2'd0);
  assign bus.lives = lives_q;
`else
  assign retry_s   = 1'b0;
`endif

  // A failed press either replays the current level (spending a life) or ends the game.
  assign fail_state_s = retry_s ? S_BLINK : S_LOSE;
  assign fail_step_s  = retry_s ? '0 : step_q;
  assign fail_lives_s = retry_s ? (lives_q - 2'd1) : lives_q;
  assign step_inc_s   = step_q + LW'(1);
  assign timeout_s    = (TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST);

  // Next-state and counter update logic.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    step_d        = step_q;
    timer_d       = timer_q;
    lives_d       = lives_q;
    blink_first_d = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start_game) begin
          state_d = S_GEN;
          level_d = '0;
          step_d  = '0;
          timer_d = '0;
          lives_d = 2'd3;
        end else begin
          state_d = state_q;
        end
      end
      S_GEN: begin
        if (bus.rng_ack) begin
          state_d       = S_BLINK;
          level_d       = level_q + LW'(1);
          step_d        = '0;
          blink_first_d = 1'b1;
        end else begin
          state_d = S_GEN;
        end
      end
      S_BLINK: begin
        if (bus.blinker_done) begin
          state_d = S_WAIT_IN;
          timer_d = '0;
        end else begin
          state_d = S_BLINK;
        end
      end
      S_WAIT_IN: begin
        timer_d = timer_q + TW'(1);
        // A press on the expiry cycle still counts.
        if (bus.input_done) begin
          state_d = S_CHECK;
          timer_d = '0;
        end else if (timeout_s) begin
          state_d       = fail_state_s;
          step_d        = fail_step_s;
          lives_d       = fail_lives_s;
          blink_first_d = retry_s;
        end else begin
          state_d = S_WAIT_IN;
        end
      end
      S_CHECK: begin
        timer_d = '0;
        if (!bus.cmp_good) begin
          state_d       = fail_state_s;
          step_d        = fail_step_s;
          lives_d       = fail_lives_s;
          blink_first_d = retry_s;
        end else if (step_inc_s < level_q) begin
          state_d = S_WAIT_IN;
          step_d  = step_inc_s;
        end else if (level_q < MAX_LVL) begin
          state_d = S_GEN;
          step_d  = step_inc_s;
        end else begin
          state_d = S_WIN;
          step_d  = step_inc_s;
        end
      end
      default: begin
        state_d = S_IDLE;
        level_d = '0;
        step_d  = '0;
        timer_d = '0;
        lives_d = 2'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      level_q       <= '0;
      step_q        <= '0;
      timer_q       <= '0;
      lives_q       <= 2'd0;
      blink_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      step_q        <= step_d;
      timer_q       <= timer_d;
      lives_q       <= lives_d;
      blink_first_q <= blink_first_d;
    end
  end

  // Moore output decode; an unknown state code drives everything low.
  always_comb begin
    bus.rng_req     = 1'b0;
    bus.mem_addr    = '0;
    bus.blink_start = 1'b0;
    bus.input_en    = 1'b0;
    bus.cmp_en      = 1'b0;
    bus.win         = 1'b0;
    bus.lose        = 1'b0;
    bus.level       = '0;
    bus.step        = '0;
    bus.blink_len   = '0;
    bus.state_code  = 3'd0;
    case (state_q)
      S_IDLE, S_GEN, S_BLINK, S_WAIT_IN, S_CHECK, S_WIN, S_LOSE: begin
        bus.level       = level_q;
        bus.step        = step_q;
        bus.blink_len   = level_q;
        bus.state_code  = state_q;
        bus.rng_req     = (state_q == S_GEN);
        bus.blink_start = (state_q == S_BLINK) && blink_first_q;
        bus.input_en    = (state_q == S_WAIT_IN);
        bus.cmp_en      = (state_q == S_CHECK);
        bus.win         = (state_q == S_WIN);
        bus.lose        = (state_q == S_LOSE);
        bus.mem_addr    = (state_q == S_GEN) ? level_q : step_q;
      end
      default: begin
        bus.state_code = 3'd0;
      end
    endcase
  end

  assign bus.mem_we = (state_q == S_GEN) && bus.rng_ack;

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// Randomized game-playing bench: a reference game model queues expected events,
// a negedge monitor pops and compares them whenever the controller shows one.
module tb_simon_seq_ctrl;
  localparam int MAX = 4;
  localparam int TO  = 10;
  localparam int LW  = $clog2(MAX + 1);
`ifdef SIMON_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  localparam int EV_WR = 0, EV_BL = 1, EV_CK = 2, EV_WIN = 3, EV_LOSE = 4;

  typedef struct {
    int kind;
    int a;
    int b;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic win_p = 1'b0;
  logic lose_p = 1'b0;

  simon_if #(.LW(LW)) bus ();

  simon_seq_ctrl #(.MAX_LEVEL(MAX), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_push(input int k, input int a, input int b);
    exp_q.push_back('{kind: k, a: a, b: b});
  endfunction

  task automatic mon_event(input string name, input int kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_%s: got value %0d/%0d expected no event", name, a, b);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, kind, e.kind);
      check({name, "_val"}, a, e.a);
      check({name, "_aux"}, b, e.b);
    end
  endtask

  // Monitor: every visible controller event must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (bus.mem_we === 1'b1)                     mon_event("write", EV_WR, int'(bus.mem_addr), 0);
        if (bus.blink_start === 1'b1)                mon_event("blink", EV_BL, int'(bus.blink_len), int'(bus.level));
        if (bus.cmp_en === 1'b1)                     mon_event("check", EV_CK, int'(bus.mem_addr), int'(bus.level));
        if (bus.win === 1'b1 && win_p !== 1'b1)      mon_event("win", EV_WIN, int'(bus.level), int'(bus.state_code));
        if (bus.lose === 1'b1 && lose_p !== 1'b1)    mon_event("lose", EV_LOSE, int'(bus.level), int'(bus.state_code));
      end
      win_p  = bus.win;
      lose_p = bus.lose;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
    check("start_rng_req", bus.rng_req, 1);
    check("start_state_gen", bus.state_code, 1);
  endtask

  task automatic do_gen();
    repeat ($urandom_range(0, 3)) tick();
    bus.rng_ack = 1'b1;
    tick();
    bus.rng_ack = 1'b0;
  endtask

  task automatic do_blink();
    repeat ($urandom_range(0, 3)) tick();
    bus.blinker_done = 1'b1;
    tick();
    bus.blinker_done = 1'b0;
  endtask

  task automatic do_press(input int d, input bit good);
    repeat (d) tick();
    bus.input_done = 1'b1;
    tick();
    bus.input_done = 1'b0;
    bus.cmp_good   = good;
    tick();
    bus.cmp_good   = 1'($urandom_range(0, 1));
  endtask

  // Plays one game from the model's point of view; f_kind: 1 = bad press, 2 = timeout at (f_lvl, f_step).
  task automatic play_game(input int bad_pct, input int to_pct, input int f_lvl, input int f_step,
                           input int f_kind);
    int lvl, step, lives, r, kind, d;
    bit done, replay, fail, forced_used;
    lvl = 0;
    lives = 3;
    done = 1'b0;
    forced_used = 1'b0;
    pulse_start();
    while (!done) begin
      exp_push(EV_WR, lvl, 0);
      exp_push(EV_BL, lvl + 1, lvl + 1);
      lvl++;
      do_gen();
      replay = 1'b1;
      while (replay) begin
        replay = 1'b0;
        do_blink();
        step = 0;
        while (step < lvl && !replay && !done) begin
          r = $urandom_range(0, 99);
          kind = (r < to_pct) ? 2 : ((r < to_pct + bad_pct) ? 1 : 0);
          if (!forced_used && lvl == f_lvl && step == f_step) begin
            kind = f_kind;
            forced_used = 1'b1;
          end
          fail = (kind != 0);
          if (kind != 2) exp_push(EV_CK, step, lvl);
          if (fail) begin
            if (RETRY && lives > 0) begin
              lives--;
              exp_push(EV_BL, lvl, lvl);
              replay = 1'b1;
            end else begin
              exp_push(EV_LOSE, lvl, 6);
              done = 1'b1;
            end
          end
          if (kind == 2) begin
            repeat (TO - 1) tick();
            check("timeout_not_early", bus.state_code, 3);
            tick();
            check("timeout_expiry", bus.state_code, replay ? 2 : 6);
          end else begin
            d = ($urandom_range(0, 3) == 0) ? TO - 1 : int'($urandom_range(0, TO - 1));
            do_press(d, kind == 0);
          end
`ifdef SIMON_RETRY_EN
          if (fail) check("lives", bus.lives, lives);
`endif
          if (!fail) step++;
        end
      end
      if (!done && lvl == MAX) begin
        exp_push(EV_WIN, lvl, 5);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start_game   = 1'b0;
    bus.rng_ack      = 1'b0;
    bus.blinker_done = 1'b0;
    bus.input_done   = 1'b0;
    bus.cmp_good     = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_state", bus.state_code, 0);
    check("rst_rng_req", bus.rng_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_level", bus.level, 0);
    check("rst_step", bus.step, 0);
    check("rst_win", bus.win, 0);
    check("rst_lose", bus.lose, 0);
    check("rst_input_en", bus.input_en, 0);
    check("rst_cmp_en", bus.cmp_en, 0);
    check("rst_blink_start", bus.blink_start, 0);
    tick();

    play_game(0, 0, 0, 0, 0);
    play_game(0, 0, 2, 1, 1);
    play_game(0, 0, 1, 0, 2);
    play_game(0, 0, 3, 2, 2);
    repeat (16) play_game(8, 3, 0, 0, 0);
    repeat (4) play_game(30, 10, 0, 0, 0);

    // Reset in the middle of a round aborts to IDLE.
    pulse_start();
    exp_push(EV_WR, 0, 0);
    exp_push(EV_BL, 1, 1);
    do_gen();
    do_blink();
    tick();
    check("mid_wait_in", bus.state_code, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_state", bus.state_code, 0);
    check("midrst_level", bus.level, 0);
    check("midrst_win", bus.win, 0);
    check("midrst_lose", bus.lose, 0);
    check("midrst_input_en", bus.input_en, 0);

    // start_game during BLINK has no effect.
    pulse_start();
    exp_push(EV_WR, 0, 0);
    exp_push(EV_BL, 1, 1);
    do_gen();
    bus.start_game = 1'b1;
    tick();
    bus.start_game = 1'b0;
    check("blink_ignores_start", bus.state_code, 2);
    check("blink_level", bus.level, 1);
    bus.blinker_done = 1'b1;
    tick();
    bus.blinker_done = 1'b0;
    check("blink_to_wait_in", bus.state_code, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
